rdma_pkt_trimmer: RTL and testbench

- Parametrised successor to the single-opcode read-request trimmer on the RDMA network path. Sits between the HLS packet generator and the network TX stream.
- Matches first beats against a header value plus a table of N_RULES opcodes. Truncates each matching packet to its rule's byte length, which may span several beats, and consumes all remaining beats.
- Non-matching packets pass through unchanged. Provides an optional output register slice and saturating statistics counters.

---
 rtl/rdma_pkt_trimmer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rdma_pkt_trimmer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdma_pkt_trimmer.sv
// rdma_pkt_trimmer: truncates RDMA packets whose first beat matches a header
// value and one of N_RULES opcodes to that rule's byte length, discarding the
// rest of the packet. Everything else streams through untouched. An optional
// two-entry output skid keeps full throughput with one cycle of latency.
module rdma_pkt_trimmer #(
   parameter int                    DATA_W   = 512,
   parameter int                    HDR_OFF  = 0,
   parameter int                    HDR_W    = 16,
   parameter logic [HDR_W-1:0]      HDR_VAL  = 16'h0245,
   parameter int                    OPC_OFF  = 224,
   parameter int                    N_RULES  = 2,
   parameter logic [N_RULES*8-1:0]  RULE_OPC = {8'h0a, 8'h0c},
   parameter logic [N_RULES*16-1:0] RULE_LEN = {16'd100, 16'd56},
   parameter int                    OUT_REG  = 1,
   parameter int                    CNT_W    = 32
) (
   input  logic                nclk,
   input  logic                nresetn,
   input  logic                input_stream_tvalid,
   output logic                input_stream_tready,
   input  logic [DATA_W-1:0]   input_stream_tdata,
   input  logic [DATA_W/8-1:0] input_stream_tkeep,
   input  logic                input_stream_tlast,
   output logic                output_stream_tvalid,
   input  logic                output_stream_tready,
   output logic [DATA_W-1:0]   output_stream_tdata,
   output logic [DATA_W/8-1:0] output_stream_tkeep,
   output logic                output_stream_tlast,
   input  logic                trim_en,
   output logic [CNT_W-1:0]    trimmed_pkts,
   output logic [CNT_W-1:0]    dropped_beats
);

   localparam int BYTES = DATA_W / 8;

   typedef enum logic [1:0] {S_SOP, S_PASS, S_KEEP, S_DROP} state_t;

   // Reject illegal configurations at elaboration time.
   generate
      if ((DATA_W % 8) != 0) begin : g_bad_width
         $fatal(1, "DATA_W must be a multiple of 8");
      end
      if (N_RULES < 1) begin : g_bad_rules
         $fatal(1, "N_RULES must be at least 1");
      end
      for (genvar gi = 0; gi < N_RULES; gi++) begin : g_rule_chk
         if (RULE_LEN[gi*16 +: 16] == 16'd0) begin : g_bad_len
            $fatal(1, "RULE_LEN entries must be nonzero");
         end
      end
   endgenerate

   // Number of beats needed to carry len bytes.
   function automatic logic [15:0] calc_k(input logic [15:0] len);
      logic [31:0] t;
      t = (32'(len) + 32'(BYTES - 1)) / 32'(BYTES);
      return t[15:0];
   endfunction

   // Bytes that remain valid in the last kept beat.
   function automatic logic [15:0] calc_r(input logic [15:0] len, input logic [15:0] k);
      logic [31:0] t;
      t = 32'(len) - (32'(k) - 32'd1) * 32'(BYTES);
      return t[15:0];
   endfunction

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t            state, state_nxt;
   logic [15:0]       cnt, cnt_nxt, beat_num;
   logic [15:0]       kbeats, rbytes;
   logic              latch, cut;
   logic              rule_hit, hdr_ok, match;
   logic [15:0]       rule_len, sel_k, sel_r, cut_r;
   logic              fire, side_ready;
   logic [DATA_W-1:0] beat_data;
   logic [BYTES-1:0]  beat_keep;
   logic              beat_last;

   // Rule lookup on the current beat; the lowest-numbered matching rule wins.
   always_comb begin
      rule_hit = 1'b0;
      rule_len = 16'd0;
      for (int i = N_RULES - 1; i >= 0; i--) begin
         if (input_stream_tdata[OPC_OFF +: 8] == RULE_OPC[i*8 +: 8]) begin
            rule_hit = 1'b1;
            rule_len = RULE_LEN[i*16 +: 16];
         end
      end
   end

   assign hdr_ok   = (input_stream_tdata[HDR_OFF +: HDR_W] == HDR_VAL);
   assign match    = trim_en & hdr_ok & rule_hit;
   assign sel_k    = calc_k(rule_len);
   assign sel_r    = calc_r(rule_len, sel_k);
   assign beat_num = cnt + 16'd1;
   // A cut in SOP uses the rule just looked up; a cut in KEEP uses the latched one.
   assign cut_r    = (state == S_KEEP) ? rbytes : sel_r;

   assign input_stream_tready = (state == S_DROP) | side_ready;
   assign fire                = input_stream_tvalid & input_stream_tready;

   // Next state and cut decision, computed as if the presented beat is accepted.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      latch     = 1'b0;
      cut       = 1'b0;
      case (state)
         S_SOP: begin
            if (match && !input_stream_tlast) begin
               latch = 1'b1;
               if (sel_k > 16'd1) begin
                  state_nxt = S_KEEP;
                  cnt_nxt   = 16'd1;
               end else begin
                  cut       = 1'b1;
                  state_nxt = S_DROP;
               end
            end else if (!input_stream_tlast) begin
               state_nxt = S_PASS;
            end
         end
         S_PASS: begin
            if (input_stream_tlast) state_nxt = S_SOP;
         end
         S_KEEP: begin
            cnt_nxt = beat_num;
            if (beat_num == kbeats) begin
               if (!input_stream_tlast) begin
                  cut       = 1'b1;
                  state_nxt = S_DROP;
               end else begin
                  state_nxt = S_SOP;
               end
            end else if (input_stream_tlast) begin
               state_nxt = S_SOP;
            end
         end
         S_DROP: begin
            if (input_stream_tlast) state_nxt = S_SOP;
         end
         default: state_nxt = S_SOP;
      endcase
   end

   // Beat actually presented downstream: unchanged, or masked to R bytes on a cut.
   always_comb begin
      beat_data = input_stream_tdata;
      beat_keep = input_stream_tkeep;
      beat_last = input_stream_tlast;
      if (cut) begin
         beat_last = 1'b1;
         for (int b = 0; b < BYTES; b++) begin
            if (16'(b) >= cut_r) begin
               beat_data[b*8 +: 8] = 8'h00;
               beat_keep[b]        = 1'b0;
            end
         end
      end
   end

   // FSM, beat counter and latched rule geometry advance only on accepted beats.
   always_ff @(posedge nclk or negedge nresetn) begin
      if (!nresetn) begin
         state  <= S_SOP;
         cnt    <= 16'd0;
         kbeats <= 16'd0;
         rbytes <= 16'd0;
      end else if (fire) begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (latch) begin
            kbeats <= sel_k;
            rbytes <= sel_r;
         end
      end
   end

   // Saturating statistics: one cut packet count, one count per discarded beat.
   always_ff @(posedge nclk or negedge nresetn) begin
      if (!nresetn) begin
         trimmed_pkts  <= '0;
         dropped_beats <= '0;
      end else begin
         if (fire && cut) trimmed_pkts <= sat_inc(trimmed_pkts);
         if (fire && (state == S_DROP)) dropped_beats <= sat_inc(dropped_beats);
      end
   end

   generate
      if (OUT_REG != 0) begin : g_slice
         logic              vld_p0, vld_p1;
         logic [DATA_W-1:0] data_p0, data_p1;
         logic [BYTES-1:0]  keep_p0, keep_p1;
         logic              last_p0, last_p1;
         logic              push, pop;

         assign push       = fire & (state != S_DROP);
         assign pop        = vld_p0 & output_stream_tready;
         assign side_ready = ~vld_p1;

         // Two-entry skid: p0 is the visible head, p1 absorbs a beat while the head stalls.
         always_ff @(posedge nclk or negedge nresetn) begin
            if (!nresetn) begin
               vld_p0  <= 1'b0;
               vld_p1  <= 1'b0;
               data_p0 <= '0;
               data_p1 <= '0;
               keep_p0 <= '0;
               keep_p1 <= '0;
               last_p0 <= 1'b0;
               last_p1 <= 1'b0;
            end else begin
               case ({push, pop})
                  2'b10: begin
                     if (!vld_p0) begin
                        vld_p0  <= 1'b1;
                        data_p0 <= beat_data;
                        keep_p0 <= beat_keep;
                        last_p0 <= beat_last;
                     end else begin
                        vld_p1  <= 1'b1;
                        data_p1 <= beat_data;
                        keep_p1 <= beat_keep;
                        last_p1 <= beat_last;
                     end
                  end
                  2'b01: begin
                     vld_p0  <= vld_p1;
                     vld_p1  <= 1'b0;
                     data_p0 <= data_p1;
                     keep_p0 <= keep_p1;
                     last_p0 <= last_p1;
                  end
                  2'b11: begin
                     if (vld_p1) begin
                        data_p0 <= data_p1;
                        keep_p0 <= keep_p1;
                        last_p0 <= last_p1;
                        data_p1 <= beat_data;
                        keep_p1 <= beat_keep;
                        last_p1 <= beat_last;
                     end else begin
                        data_p0 <= beat_data;
                        keep_p0 <= beat_keep;
                        last_p0 <= beat_last;
                     end
                  end
                  default: ;
               endcase
            end
         end

         assign output_stream_tvalid = vld_p0;
         assign output_stream_tdata  = data_p0;
         assign output_stream_tkeep  = keep_p0;
         assign output_stream_tlast  = last_p0;
      end else begin : g_comb
         assign side_ready           = output_stream_tready;
         assign output_stream_tvalid = input_stream_tvalid & (state != S_DROP);
         assign output_stream_tdata  = beat_data;
         assign output_stream_tkeep  = beat_keep;
         assign output_stream_tlast  = beat_last;
      end
   endgenerate

endmodule

// File: tb/tb_rdma_pkt_trimmer.sv
// Bench for rdma_pkt_trimmer: a registered-output instance (r) and a
// combinational-output instance (c) share the input data lines but have
// their own valid/ready, so each phase exercises one of them.
module tb_rdma_pkt_trimmer;

   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
   } beat_t;

   localparam int ROLE_FWD  = 0;
   localparam int ROLE_CUT  = 1;
   localparam int ROLE_DROP = 2;

   logic nclk = 1'b0;
   logic nresetn = 1'b0;
   always #5 nclk = ~nclk;

   logic [511:0] in_data;
   logic [63:0]  in_keep;
   logic         in_last;
   logic         trim_en;

   logic         in_valid_r, in_ready_r, out_valid_r, out_ready_r, out_last_r;
   logic [511:0] out_data_r;
   logic [63:0]  out_keep_r;
   logic [31:0]  trim_r, drop_r;

   logic         in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_last_c;
   logic [511:0] out_data_c;
   logic [63:0]  out_keep_c;
   logic [31:0]  trim_c, drop_c;

   int n_chk = 0;
   int n_pass = 0;
   int n_out_r = 0;
   int n_out_c = 0;
   beat_t q_r[$];
   beat_t q_c[$];
   logic [31:0] exp_trim_r = 0, exp_drop_r = 0, exp_trim_c = 0, exp_drop_c = 0;
   bit bp_on = 1'b0;

   logic [511:0] last_d_r;
   logic [63:0]  last_k_r;
   logic         last_l_r;

   logic [511:0] pkt_d[8];
   logic [63:0]  pkt_k[8];

   rdma_pkt_trimmer #(.OUT_REG(1)) dut_r (
      .nclk(nclk), .nresetn(nresetn),
      .input_stream_tvalid(in_valid_r), .input_stream_tready(in_ready_r),
      .input_stream_tdata(in_data), .input_stream_tkeep(in_keep), .input_stream_tlast(in_last),
      .output_stream_tvalid(out_valid_r), .output_stream_tready(out_ready_r),
      .output_stream_tdata(out_data_r), .output_stream_tkeep(out_keep_r), .output_stream_tlast(out_last_r),
      .trim_en(trim_en), .trimmed_pkts(trim_r), .dropped_beats(drop_r)
   );

   rdma_pkt_trimmer #(.OUT_REG(0)) dut_c (
      .nclk(nclk), .nresetn(nresetn),
      .input_stream_tvalid(in_valid_c), .input_stream_tready(in_ready_c),
      .input_stream_tdata(in_data), .input_stream_tkeep(in_keep), .input_stream_tlast(in_last),
      .output_stream_tvalid(out_valid_c), .output_stream_tready(out_ready_c),
      .output_stream_tdata(out_data_c), .output_stream_tkeep(out_keep_c), .output_stream_tlast(out_last_c),
      .trim_en(trim_en), .trimmed_pkts(trim_c), .dropped_beats(drop_c)
   );

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   // Downstream ready: random when backpressure is enabled, otherwise always 1.
   initial begin
      out_ready_r = 1'b1;
      out_ready_c = 1'b1;
      forever begin
         @(posedge nclk);
         #1;
         out_ready_r = bp_on ? ($urandom_range(0, 1) == 1) : 1'b1;
         out_ready_c = 1'b1;
      end
   end

   // Compare process: outputs vs. scoreboard, hold stability, counters, every cycle.
   initial begin
      beat_t e;
      logic pv_r, prd_r;
      logic [511:0] pd_r;
      logic [64:0] pkl_r;
      pv_r = 1'b0;
      prd_r = 1'b0;
      pd_r = '0;
      pkl_r = '0;
      forever begin
         @(negedge nclk);
         if (!nresetn) begin
            pv_r = 1'b0;
            continue;
         end
         if (pv_r && !prd_r) begin
            chk("hold_valid_r", 512'(out_valid_r), 512'(1));
            chk("hold_data_r", out_data_r, pd_r);
            chk("hold_keep_last_r", 512'({out_keep_r, out_last_r}), 512'(pkl_r));
         end
         pv_r = out_valid_r;
         prd_r = out_ready_r;
         pd_r = out_data_r;
         pkl_r = {out_keep_r, out_last_r};
         if (out_valid_r && out_ready_r) begin
            if (q_r.size() == 0) chk("spurious_out_r", 512'(out_valid_r), 512'(0));
            else begin
               e = q_r.pop_front();
               chk("out_data_r", out_data_r, e.d);
               chk("out_keep_r", 512'(out_keep_r), 512'(e.k));
               chk("out_last_r", 512'(out_last_r), 512'(e.l));
               last_d_r = out_data_r;
               last_k_r = out_keep_r;
               last_l_r = out_last_r;
               n_out_r++;
            end
         end
         if (out_valid_c && out_ready_c) begin
            if (q_c.size() == 0) chk("spurious_out_c", 512'(out_valid_c), 512'(0));
            else begin
               e = q_c.pop_front();
               chk("out_data_c", out_data_c, e.d);
               chk("out_keep_c", 512'(out_keep_c), 512'(e.k));
               chk("out_last_c", 512'(out_last_c), 512'(e.l));
               n_out_c++;
            end
         end
         chk("trimmed_r", 512'(trim_r), 512'(exp_trim_r));
         chk("dropped_r", 512'(drop_r), 512'(exp_drop_r));
         chk("trimmed_c", 512'(trim_c), 512'(exp_trim_c));
         chk("dropped_c", 512'(drop_c), 512'(exp_drop_c));
      end
   end

   // Present one beat to instance sel (0=r, 1=c) and wait, bounded, for acceptance.
   task automatic drive_beat(input bit sel, input logic [511:0] d, input logic [63:0] k,
                             input logic l, input int role);
      bit got = 1'b0;
      in_data = d;
      in_keep = k;
      in_last = l;
      if (sel) in_valid_c = 1'b1;
      else in_valid_r = 1'b1;
      for (int w = 0; w < 1000 && !got; w++) begin
         @(negedge nclk);
         if (role == ROLE_DROP && w == 0)
            chk(sel ? "drop_ready_c" : "drop_ready_r", 512'(sel ? in_ready_c : in_ready_r), 512'(1));
         if (sel ? in_ready_c : in_ready_r) begin
            got = 1'b1;
            if (sel) begin
               chk("zero_latency_valid_c", 512'(out_valid_c), 512'(role != ROLE_DROP));
               chk("no_bubble_c", 512'(w == 0), 512'(1));
            end
         end
      end
      chk("input_accept", 512'(got), 512'(1));
      @(posedge nclk);
      #1;
      if (got) begin
         if (role == ROLE_CUT) begin
            if (sel) exp_trim_c++;
            else exp_trim_r++;
         end
         if (role == ROLE_DROP) begin
            if (sel) exp_drop_c++;
            else exp_drop_r++;
         end
      end
      in_valid_r = 1'b0;
      in_valid_c = 1'b0;
   endtask

   task automatic make_pkt(input logic [15:0] hdr, input logic [7:0] opc, input int n,
                           input logic [31:0] seed);
      for (int j = 0; j < n; j++) begin
         pkt_d[j] = {16{seed + 32'(j) * 32'h01010101}};
         pkt_k[j] = (j == n - 1) ? 64'h0000ffffffffffff : '1;
      end
      pkt_d[0][15:0] = hdr;
      pkt_d[0][231:224] = opc;
   endtask

   // Model: a matched packet longer than K beats becomes K beats, the K-th cut
   // to R bytes; every other packet is reproduced exactly.
   task automatic send_pkt(input bit sel, input int n, input logic te0, input logic te1);
      logic [15:0] len;
      int kk, rb;
      bit trunc;
      beat_t e;
      int roles[8];
      len = 16'd0;
      if (te0 && pkt_d[0][15:0] == 16'h0245) begin
         if (pkt_d[0][231:224] == 8'h0c) len = 16'd56;
         else if (pkt_d[0][231:224] == 8'h0a) len = 16'd100;
      end
      kk = (int'(len) + 63) / 64;
      rb = int'(len) - (kk - 1) * 64;
      trunc = (len != 16'd0) && (n > kk);
      for (int j = 0; j < n; j++) begin
         roles[j] = ROLE_FWD;
         e.d = pkt_d[j];
         e.k = pkt_k[j];
         e.l = (j == n - 1);
         if (trunc && j == kk - 1) begin
            roles[j] = ROLE_CUT;
            e.l = 1'b1;
            for (int b = rb; b < 64; b++) begin
               e.d[b*8 +: 8] = 8'h00;
               e.k[b] = 1'b0;
            end
         end else if (trunc && j >= kk) begin
            roles[j] = ROLE_DROP;
         end
         if (roles[j] != ROLE_DROP) begin
            if (sel) q_c.push_back(e);
            else q_r.push_back(e);
         end
      end
      for (int j = 0; j < n; j++) begin
         trim_en = (j == 0) ? te0 : te1;
         drive_beat(sel, pkt_d[j], pkt_k[j], (j == n - 1), roles[j]);
      end
   endtask

   task automatic wait_drain();
      for (int w = 0; w < 300 && (q_r.size() != 0 || q_c.size() != 0); w++) @(negedge nclk);
      @(negedge nclk);
      chk("drain_r", 512'(q_r.size()), 512'(0));
      chk("drain_c", 512'(q_c.size()), 512'(0));
      @(posedge nclk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      beat_t e;
      in_valid_r = 1'b0;
      in_valid_c = 1'b0;
      in_data = '0;
      in_keep = '0;
      in_last = 1'b0;
      trim_en = 1'b1;

      // Reset state
      repeat (3) @(posedge nclk);
      #1;
      chk("rst_valid_r", 512'(out_valid_r), 512'(0));
      chk("rst_data_r", out_data_r, 512'(0));
      chk("rst_keep_r", 512'(out_keep_r), 512'(0));
      chk("rst_last_r", 512'(out_last_r), 512'(0));
      chk("rst_trim_r", 512'(trim_r), 512'(0));
      chk("rst_drop_r", 512'(drop_r), 512'(0));
      nresetn = 1'b1;
      @(posedge nclk);
      #1;
      chk("idle_ready_r", 512'(in_ready_r), 512'(1));
      chk("idle_ready_c", 512'(in_ready_c), 512'(1));

      // 2-beat opcode 0x0c packet, L=56: one cut beat
      base = n_out_r;
      make_pkt(16'h0245, 8'h0c, 2, 32'h11223344);
      send_pkt(0, 2, 1'b1, 1'b1);
      wait_drain();
      chk("t1_beats", 512'(n_out_r - base), 512'(1));
      chk("t1_keep", 512'(last_k_r), 512'(64'h00ffffffffffffff));
      chk("t1_last", 512'(last_l_r), 512'(1));
      chk("t1_hi_zero", 512'(last_d_r[511:448]), 512'(0));
      chk("t1_lo_data", 512'(last_d_r[447:0]), 512'(pkt_d[0][447:0]));
      chk("t1_trimmed", 512'(trim_r), 512'(1));
      chk("t1_dropped", 512'(drop_r), 512'(1));

      // 4-beat opcode 0x0a packet, L=100: full beat then 36-byte beat
      base = n_out_r;
      make_pkt(16'h0245, 8'h0a, 4, 32'h21324354);
      send_pkt(0, 4, 1'b1, 1'b1);
      wait_drain();
      chk("t2_beats", 512'(n_out_r - base), 512'(2));
      chk("t2_keep", 512'(last_k_r), 512'(64'h0000000fffffffff));
      chk("t2_trimmed", 512'(trim_r), 512'(2));
      chk("t2_dropped", 512'(drop_r), 512'(3));

      // Same packet under random backpressure
      bp_on = 1'b1;
      base = n_out_r;
      send_pkt(0, 4, 1'b1, 1'b1);
      wait_drain();
      chk("t2b_beats", 512'(n_out_r - base), 512'(2));
      chk("t2b_keep", 512'(last_k_r), 512'(64'h0000000fffffffff));
      chk("t2b_trimmed", 512'(trim_r), 512'(3));
      chk("t2b_dropped", 512'(drop_r), 512'(5));

      // Mixed stream with backpressure: non-match then single-beat matches
      base = n_out_r;
      make_pkt(16'h0245, 8'h55, 3, 32'h31425364);
      send_pkt(0, 3, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         make_pkt(16'h0245, 8'h0c, 1, 32'h41526374 + 32'(i));
         send_pkt(0, 1, 1'b1, 1'b1);
      end
      wait_drain();
      bp_on = 1'b0;
      chk("t3_beats", 512'(n_out_r - base), 512'(6));
      chk("t3_trimmed", 512'(trim_r), 512'(3));
      chk("t3_dropped", 512'(drop_r), 512'(5));

      // trim_en low, trim_en raised mid-packet, wrong header, exact length
      base = n_out_r;
      make_pkt(16'h0245, 8'h0c, 2, 32'h51627384);
      send_pkt(0, 2, 1'b0, 1'b0);
      send_pkt(0, 2, 1'b0, 1'b1);
      make_pkt(16'h0246, 8'h0c, 2, 32'h61728394);
      send_pkt(0, 2, 1'b1, 1'b1);
      make_pkt(16'h0245, 8'h0a, 2, 32'h718293a4);
      send_pkt(0, 2, 1'b1, 1'b1);
      wait_drain();
      chk("t4_beats", 512'(n_out_r - base), 512'(8));
      chk("t4_trimmed", 512'(trim_r), 512'(3));
      chk("t4_dropped", 512'(drop_r), 512'(5));

      // Reset asserted while the third beat of a 0x0a packet sits in DROP
      make_pkt(16'h0245, 8'h0a, 4, 32'h8192a3b4);
      trim_en = 1'b1;
      e.d = pkt_d[0];
      e.k = pkt_k[0];
      e.l = 1'b0;
      q_r.push_back(e);
      e.d = pkt_d[1];
      for (int b = 36; b < 64; b++) e.d[b*8 +: 8] = 8'h00;
      e.k = 64'h0000000fffffffff;
      e.l = 1'b1;
      q_r.push_back(e);
      drive_beat(0, pkt_d[0], pkt_k[0], 1'b0, ROLE_FWD);
      drive_beat(0, pkt_d[1], pkt_k[1], 1'b0, ROLE_CUT);
      wait_drain();
      in_data = pkt_d[2];
      in_keep = pkt_k[2];
      in_last = 1'b0;
      in_valid_r = 1'b1;
      #2;
      nresetn = 1'b0;
      exp_trim_r = 0;
      exp_drop_r = 0;
      exp_trim_c = 0;
      exp_drop_c = 0;
      q_r.delete();
      q_c.delete();
      #1;
      chk("mid_rst_valid_r", 512'(out_valid_r), 512'(0));
      chk("mid_rst_data_r", out_data_r, 512'(0));
      chk("mid_rst_keep_r", 512'(out_keep_r), 512'(0));
      chk("mid_rst_last_r", 512'(out_last_r), 512'(0));
      chk("mid_rst_trim_r", 512'(trim_r), 512'(0));
      chk("mid_rst_drop_r", 512'(drop_r), 512'(0));
      @(posedge nclk);
      #1;
      in_valid_r = 1'b0;
      nresetn = 1'b1;
      @(posedge nclk);
      #1;
      make_pkt(16'h0245, 8'h0c, 2, 32'h91a2b3c4);
      send_pkt(0, 2, 1'b1, 1'b1);
      wait_drain();
      chk("t5_keep", 512'(last_k_r), 512'(64'h00ffffffffffffff));
      chk("t5_trimmed", 512'(trim_r), 512'(1));
      chk("t5_dropped", 512'(drop_r), 512'(1));

      // Combinational-output instance, back-to-back matching packets
      base = n_out_c;
      make_pkt(16'h0245, 8'h0c, 2, 32'ha1b2c3d4);
      send_pkt(1, 2, 1'b1, 1'b1);
      make_pkt(16'h0245, 8'h0c, 2, 32'hb1c2d3e4);
      send_pkt(1, 2, 1'b1, 1'b1);
      make_pkt(16'h0245, 8'h0a, 3, 32'hc1d2e3f4);
      send_pkt(1, 3, 1'b1, 1'b1);
      wait_drain();
      chk("t6_beats_c", 512'(n_out_c - base), 512'(4));
      chk("t6_trimmed_c", 512'(trim_c), 512'(3));
      chk("t6_dropped_c", 512'(drop_c), 512'(3));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
